// File: rtl/mmu_cfg_regs.sv
// -----------------------------------------------------------------------------
// mmu_cfg_regs
//   MMU configuration register block. Holds the CPU and supervisor root
//   pointers (64-bit), the translation control register, NUM_TT transparent
//   translation registers and the MMU status register. The CPU reaches the
//   registers through a valid/ready request port with a registered one-cycle
//   response. A write that changes the translation context (CRP_LO, SRP_LO
//   or TC) starts an ATC flush handshake once the response has been given.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   req_*_i/_o       register request: valid/ready, we, addr, wdata, be
//   rsp_*_o          response strobe, read data, error flag
//   crp_o, srp_o     root pointers {HI,LO}
//   tc_o, tt_o       translation control, TT[i] at [32i+31:32i]
//   mmusr_o          {sticky[15:8], 5'b0, level[2:0]}
//   sts_*_i          table walker status inputs
//   flush_req_o/ack  ATC flush handshake
// -----------------------------------------------------------------------------
module mmu_cfg_regs #(
  parameter int NUM_TT   = 2,
  parameter int PA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [3:0]            req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_be_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [63:0]           crp_o,
  output logic [63:0]           srp_o,
  output logic [31:0]           tc_o,
  output logic [NUM_TT*32-1:0]  tt_o,
  output logic [15:0]           mmusr_o,
  input  logic [7:0]            sts_set_i,
  input  logic                  sts_load_i,
  input  logic [2:0]            sts_level_i,
  output logic                  flush_req_o,
  input  logic                  flush_ack_i
);

  typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_e;

  // Table-address bits above PA_WIDTH in the LO root-pointer words stay 0.
  localparam logic [31:0] LO_MASK = (PA_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                    32'((64'd1 << PA_WIDTH) - 64'd1);

  state_e      state_q, state_d;
  logic [31:0] crp_hi_q, crp_hi_d, crp_lo_q, crp_lo_d;
  logic [31:0] srp_hi_q, srp_hi_d, srp_lo_q, srp_lo_d;
  logic [31:0] tc_q, tc_d;
  logic [31:0] tt_q [NUM_TT];
  logic [31:0] tt_d [NUM_TT];
  logic [7:0]  sts_q, sts_d;
  logic [2:0]  lvl_q, lvl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        flush_pend_q, flush_pend_d;

  logic        hit;
  logic [31:0] rd_val;
  logic [7:0]  w1c_clr;
  logic        wr_en;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    crp_hi_d     = crp_hi_q;
    crp_lo_d     = crp_lo_q;
    srp_hi_d     = srp_hi_q;
    srp_lo_d     = srp_lo_q;
    tc_d         = tc_q;
    tt_d         = tt_q;
    lvl_d        = lvl_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;
    hit          = 1'b1;
    rd_val       = 32'h0;
    w1c_clr      = 8'h0;
    wr_en        = 1'b0;

    // Address decode, shared by reads and writes.
    case (req_addr_i)
      4'd0:    rd_val = crp_hi_q;
      4'd1:    rd_val = crp_lo_q;
      4'd2:    rd_val = srp_hi_q;
      4'd3:    rd_val = srp_lo_q;
      4'd4:    rd_val = tc_q;
      4'd5:    rd_val = {16'h0, sts_q, 5'b0, lvl_q};
      default: hit = 1'b0;
    endcase
    for (int i = 0; i < NUM_TT; i++) begin
      if (req_addr_i == 4'(8 + i)) begin
        hit    = 1'b1;
        rd_val = tt_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d      = RESP;
          wr_en        = req_we_i && hit;
          err_d        = !hit;
          rdata_d      = (hit && !req_we_i) ? rd_val : 32'h0;
          flush_pend_d = req_we_i && (|req_be_i) &&
                         (req_addr_i == 4'd1 || req_addr_i == 4'd3 ||
                          req_addr_i == 4'd4);
        end
      end
      RESP:    state_d = flush_pend_q ? FLUSH : IDLE;
      FLUSH:   if (flush_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      case (req_addr_i)
        4'd0: crp_hi_d = merge_be(crp_hi_q, req_wdata_i, req_be_i);
        4'd1: crp_lo_d = merge_be(crp_lo_q, req_wdata_i, req_be_i) & LO_MASK;
        4'd2: srp_hi_d = merge_be(srp_hi_q, req_wdata_i, req_be_i);
        4'd3: srp_lo_d = merge_be(srp_lo_q, req_wdata_i, req_be_i) & LO_MASK;
        4'd4: tc_d     = merge_be(tc_q, req_wdata_i, req_be_i);
        4'd5: w1c_clr  = req_be_i[1] ? req_wdata_i[15:8] : 8'h0;
        default: begin
          for (int i = 0; i < NUM_TT; i++)
            if (req_addr_i == 4'(8 + i))
              tt_d[i] = merge_be(tt_q[i], req_wdata_i, req_be_i);
        end
      endcase
    end

    // Walker set is applied after the CPU clear, so set wins on a collision.
    sts_d = (sts_q & ~w1c_clr) | sts_set_i;
    if (sts_load_i) lvl_d = sts_level_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      crp_hi_q     <= '0;
      crp_lo_q     <= '0;
      srp_hi_q     <= '0;
      srp_lo_q     <= '0;
      tc_q         <= '0;
      // NOTE: the TT array is reset like the other registers because
      // software may read it back before ever writing it.
      for (int i = 0; i < NUM_TT; i++) tt_q[i] <= '0;
      sts_q        <= '0;
      lvl_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      crp_hi_q     <= crp_hi_d;
      crp_lo_q     <= crp_lo_d;
      srp_hi_q     <= srp_hi_d;
      srp_lo_q     <= srp_lo_d;
      tc_q         <= tc_d;
      tt_q         <= tt_d;
      sts_q        <= sts_d;
      lvl_q        <= lvl_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign flush_req_o = (state_q == FLUSH);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign crp_o       = {crp_hi_q, crp_lo_q};
  assign srp_o       = {srp_hi_q, srp_lo_q};
  assign tc_o        = tc_q;
  assign mmusr_o     = {sts_q, 5'b0, lvl_q};

  for (genvar g = 0; g < NUM_TT; g++) begin : g_tt
    assign tt_o[32*g +: 32] = tt_q[g];
  end

endmodule
